load_store_unit: RTL and testbench



---
 rtl/load_store_unit_if.sv | 20 ++
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
interface load_store_unit_if;
  logic        op_dmem_req;
  logic        op_dmem_we;
  logic [31:0] op_dmem_addr;
  logic [3:0]  op_dmem_wstrb;
  logic [31:0] op_dmem_wdata;
  logic        ip_dmem_ack;
  logic [31:0] ip_dmem_rdata;

  modport master (
    output op_dmem_req, op_dmem_we, op_dmem_addr, op_dmem_wstrb, op_dmem_wdata,
    input  ip_dmem_ack, ip_dmem_rdata
  );

  modport slave (
    input  op_dmem_req, op_dmem_we, op_dmem_addr, op_dmem_wstrb, op_dmem_wdata,
    output ip_dmem_ack, ip_dmem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory-stage load/store engine: word-aligned bus access with strobes, load extension, stall.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses end with op_bus_err, no bus cycle.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     ip_clk,
  input  logic                     ip_rst_n,
  input  logic                     ip_mem_req,
  input  logic                     ip_mem_we,
  input  logic [2:0]               ip_funct3,
  input  logic [31:0]              ip_addr,
  input  logic [31:0]              ip_wdata,
  load_store_unit_if.master        dmem,
  output logic [31:0]              op_Read_Data,
  output logic                     op_done,
  output logic                     op_stall,
  output logic                     op_bus_err
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  logic [7:0]  tmo_cnt;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;

  function automatic logic [31:0] fmt_load(input logic [31:0] rdata,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  lane);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  r = 32'(b);
      3'b001:  r = 32'(h);
      3'b100:  r = {24'h0, b};
      3'b101:  r = {16'h0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] st_strb(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      3'b000:  return 4'b0001 << lane;
      3'b001:  return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] st_data(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3)
      3'b000:  return {4{wdata[7:0]}};
      3'b001:  return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  // Byte accesses never trap; halfwords need addr[0]=0, everything else is a word access.
  function automatic logic misaligned(input logic we, input logic [2:0] f3, input logic [1:0] lane);
    logic is_byte;
    logic is_half;
    is_byte = (f3 == 3'b000) || (!we && f3 == 3'b100);
    is_half = (f3 == 3'b001) || (!we && f3 == 3'b101);
    if (is_byte)      return 1'b0;
    else if (is_half) return lane[0];
    else              return |lane;
  endfunction
`endif

  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      state              <= IDLE;
      tmo_cnt            <= '0;
      funct3_q           <= '0;
      lane_q             <= '0;
      dmem.op_dmem_req   <= 1'b0;
      dmem.op_dmem_we    <= 1'b0;
      dmem.op_dmem_addr  <= '0;
      dmem.op_dmem_wstrb <= '0;
      dmem.op_dmem_wdata <= '0;
      op_Read_Data       <= '0;
      op_done            <= 1'b0;
      op_bus_err         <= 1'b0;
    end else begin
      op_done    <= 1'b0;
      op_bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ip_mem_req) begin
            funct3_q           <= ip_funct3;
            lane_q             <= ip_addr[1:0];
            tmo_cnt            <= '0;
            dmem.op_dmem_we    <= ip_mem_we;
            dmem.op_dmem_addr  <= {ip_addr[31:2], 2'b00};
            dmem.op_dmem_wstrb <= ip_mem_we ? st_strb(ip_funct3, ip_addr[1:0]) : 4'b0000;
            dmem.op_dmem_wdata <= ip_mem_we ? st_data(ip_funct3, ip_wdata) : 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            if (misaligned(ip_mem_we, ip_funct3, ip_addr[1:0])) begin
              state      <= DONE;
              op_done    <= 1'b1;
              op_bus_err <= 1'b1;
            end else begin
              state            <= REQ;
              dmem.op_dmem_req <= 1'b1;
            end
`else
            state            <= REQ;
            dmem.op_dmem_req <= 1'b1;
`endif
          end
        end
        REQ: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (dmem.ip_dmem_ack) begin
            state            <= DONE;
            dmem.op_dmem_req <= 1'b0;
            op_done          <= 1'b1;
            if (!dmem.op_dmem_we)
              op_Read_Data <= fmt_load(dmem.ip_dmem_rdata, funct3_q, lane_q);
          end else if (tmo_cnt == TMO_LAST) begin
            state            <= DONE;
            dmem.op_dmem_req <= 1'b0;
            op_done          <= 1'b1;
            op_bus_err       <= 1'b1;
            if (!dmem.op_dmem_we)
              op_Read_Data <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stall is combinational in IDLE so the request cycle itself freezes upstream.
  always_comb begin
    op_stall = 1'b0;
    case (state)
      IDLE:    op_stall = ip_mem_req & ip_rst_n;
      REQ:     op_stall = 1'b1;
      default: op_stall = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: random loads/stores against a byte-lane reference model.
module tb_load_store_unit;

  localparam int TMO   = 16;
  localparam int NOACK = 1000;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] read_data;
  logic        done;
  logic        stall;
  logic        bus_err;

  load_store_unit_if dmem ();

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .ip_clk       (clk),
    .ip_rst_n     (rst_n),
    .ip_mem_req   (mem_req),
    .ip_mem_we    (mem_we),
    .ip_funct3    (funct3),
    .ip_addr      (addr),
    .ip_wdata     (wdata),
    .dmem         (dmem),
    .op_Read_Data (read_data),
    .op_done      (done),
    .op_stall     (stall),
    .op_bus_err   (bus_err)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_t;

  resp_t       resp_q[$];
  bus_t        bus_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  logic [31:0] rd_model = '0;
  int          resp_delay = 0;
  logic [31:0] resp_rdata = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Access size in bytes from funct3 and direction.
  function automatic int size_of(input logic we, input logic [2:0] f3);
    if (f3 == 3'd0 || (!we && f3 == 3'd4)) return 1;
    if (f3 == 3'd1 || (!we && f3 == 3'd5)) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    int          sz;
    int          off;
    logic [31:0] v;
    sz  = size_of(1'b0, f3);
    off = (sz == 4) ? 0 : (int'(a[1:0]) / sz) * sz;
    v   = rd >> (8 * off);
    if (sz == 1) begin
      v = v & 32'hFF;
      if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Memory responder: acks after resp_delay wait cycles of an outstanding request.
  initial begin
    int wcnt;
    wcnt = 0;
    dmem.ip_dmem_ack   = 1'b0;
    dmem.ip_dmem_rdata = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      dmem.ip_dmem_ack   = 1'b0;
      dmem.ip_dmem_rdata = 32'hDEAD_BEEF;
      if (rst_n && dmem.op_dmem_req) begin
        if (wcnt == resp_delay) begin
          dmem.ip_dmem_ack   = 1'b1;
          dmem.ip_dmem_rdata = resp_rdata;
        end
        wcnt++;
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: checks each bus request and each completion against the queued expectations.
  initial begin
    logic  prev_req;
    bus_t  b;
    resp_t r;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (dmem.op_dmem_req && !prev_req) begin
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got op_dmem_req=1 expected 0 (cycle %0d)", cyc);
        end else begin
          b = bus_q.pop_front();
          chk("dmem_addr",  dmem.op_dmem_addr,  b.addr);
          chk("dmem_we",    32'(dmem.op_dmem_we), 32'(b.we));
          chk("dmem_wstrb", 32'(dmem.op_dmem_wstrb), 32'(b.wstrb));
          chk("dmem_wdata", dmem.op_dmem_wdata, b.wdata);
        end
      end
      prev_req = dmem.op_dmem_req;
      if (done) begin
        if (resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got op_done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          r = resp_q.pop_front();
          chk("read_data",  read_data, r.rd);
          chk("bus_err",    32'(bus_err), 32'(r.err));
          chk("done_cycle", 32'(cyc), 32'(r.cyc));
        end
      end else begin
        chk("err_without_done", 32'(bus_err), 32'h0);
      end
    end
  end

  // Issue one access from posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int delay, input logic [31:0] rdat);
    int    sz;
    int    off;
    int    reqc;
    int    stalls;
    bit    trap;
    bit    timed_out;
    bit    seen;
    bus_t  b;
    resp_t r;
    sz   = size_of(we, f3);
    off  = (sz == 4) ? 0 : (int'(a[1:0]) / sz) * sz;
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (int'(a[1:0]) % sz) != 0;
`endif
    timed_out = !trap && delay >= TMO;
    reqc = trap ? 0 : (timed_out ? TMO : delay + 1);
    if (!trap) begin
      b.addr  = a & 32'hFFFF_FFFC;
      b.we    = we;
      b.wstrb = we ? 4'(((1 << sz) - 1) << off) : 4'h0;
      if (!we)          b.wdata = 32'h0;
      else if (sz == 1) b.wdata = (wd & 32'hFF) * 32'h0101_0101;
      else if (sz == 2) b.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
      else              b.wdata = wd;
      bus_q.push_back(b);
    end
    if (!trap && !we) rd_model = timed_out ? 32'h0 : model_load(f3, a, rdat);
    r.rd  = rd_model;
    r.err = trap || timed_out;
    r.cyc = cyc + 1 + ((reqc == 0) ? 1 : reqc);
    resp_q.push_back(r);
    resp_delay = delay;
    resp_rdata = rdat;
    mem_req = 1'b1;
    mem_we  = we;
    funct3  = f3;
    addr    = a;
    wdata   = wd;
    @(negedge clk);
    stalls = stall ? 1 : 0;
    @(posedge clk);
    #1;
    mem_req = 1'b0;
    mem_we  = 1'($urandom);
    funct3  = 3'($urandom);
    addr    = $urandom;
    wdata   = $urandom;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (stall) stalls++;
    end
    if (!seen) chk("done_wait", 32'h0, 32'h1);
    else       chk("stall_cycles", 32'(stalls), 32'(1 + reqc));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1);
  end

  initial begin
    bus_t b;
    rst_n   = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    funct3  = 3'h0;
    addr    = 32'h0;
    wdata   = 32'h0;
    #12;
    chk("rst_dmem_req",  32'(dmem.op_dmem_req), 32'h0);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_done",      32'(done), 32'h0);
    chk("rst_stall",     32'(stall), 32'h0);
    chk("rst_bus_err",   32'(bus_err), 32'h0);
    chk("rst_wstrb",     32'(dmem.op_dmem_wstrb), 32'h0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_access(1'b0, 3'b000, 32'h0000_1003, 32'h0,          0,     32'h80FF_1234);
    do_access(1'b0, 3'b101, 32'h0000_2002, 32'h0,          3,     32'h8001_7FFF);
    do_access(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00AB,  1,     32'h0);
    do_access(1'b0, 3'b010, 32'h0000_5000, 32'h0,          NOACK, 32'h0);
    do_access(1'b0, 3'b010, 32'h0000_4002, 32'h0,          1,     32'h1234_5678);
    do_access(1'b0, 3'b001, 32'h0000_6000, 32'h0,          TMO-1, 32'h0000_9ABC);

    for (int n = 0; n < 40; n++) begin
      logic we_r;
      int   d;
      we_r = 1'($urandom);
      d    = (!we_r && $urandom_range(0, 9) == 0) ? NOACK : int'($urandom_range(0, 4));
      do_access(we_r, 3'($urandom), $urandom, $urandom, d, $urandom);
    end

    // Reset while a load is outstanding: the request must drop at once and never complete.
    b.addr = 32'h0000_7000; b.we = 1'b0; b.wstrb = 4'h0; b.wdata = 32'h0;
    bus_q.push_back(b);
    resp_delay = NOACK;
    mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h0000_7000;
    @(posedge clk);
    #1;
    mem_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("req_before_reset", 32'(dmem.op_dmem_req), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_dmem_req",  32'(dmem.op_dmem_req), 32'h0);
    chk("midrst_read_data", read_data, 32'h0);
    chk("midrst_stall",     32'(stall), 32'h0);
    chk("midrst_done",      32'(done), 32'h0);
    chk("midrst_addr",      dmem.op_dmem_addr, 32'h0);
    rd_model = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_read_data", read_data, rd_model);
    chk("bus_q_drained",  32'(bus_q.size()), 32'h0);
    chk("resp_q_drained", 32'(resp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
